// File: rtl/dbi_cmd_sequencer.sv
// DBI command sequencer: emits the panel init/window command bytes, then
// forwards one frame of pixel bytes to the Type-B serializer over valid/ready.
module dbi_cmd_sequencer #(
  parameter int DATA_W       = 8,
  parameter int FRAME_BYTES  = 153600,
  parameter int RST_WAIT_CYC = 600000,
  parameter int CNT_W        = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbi_tx_start_i,
  input  logic [DATA_W-1:0] addr_soft_rst_i,
  input  logic [DATA_W-1:0] addr_disp_on_i,
  input  logic [DATA_W-1:0] addr_col_i,
  input  logic [DATA_W-1:0] addr_row_i,
  input  logic [DATA_W-1:0] addr_acs_ctrl_i,
  input  logic [DATA_W-1:0] addr_mem_wr_i,
  input  logic [DATA_W-1:0] cmd_s_col_h_i,
  input  logic [DATA_W-1:0] cmd_s_col_l_i,
  input  logic [DATA_W-1:0] cmd_e_col_h_i,
  input  logic [DATA_W-1:0] cmd_e_col_l_i,
  input  logic [DATA_W-1:0] cmd_s_row_h_i,
  input  logic [DATA_W-1:0] cmd_s_row_l_i,
  input  logic [DATA_W-1:0] cmd_e_row_h_i,
  input  logic [DATA_W-1:0] cmd_e_row_l_i,
  input  logic [DATA_W-1:0] cmd_acs_ctrl_i,
  input  logic [DATA_W-1:0] pix_data_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  output logic [DATA_W-1:0] dbi_data_o,
  output logic              dbi_dc_o,
  output logic              dbi_valid_o,
  input  logic              dbi_ready_i,
  output logic              busy_o,
  output logic              frame_done_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_SRST_CMD, S_SRST_WAIT, S_DISP_ON, S_MAD_CMD, S_MAD_DAT,
    S_COL_CMD, S_COL_PAR, S_ROW_CMD, S_ROW_PAR, S_MEMWR_CMD, S_PIXEL
  } state_t;

  localparam logic [CNT_W-1:0] LP_FRAME = CNT_W'(FRAME_BYTES);
  localparam logic [CNT_W:0]   LP_WAIT  = (CNT_W+1)'(RST_WAIT_CYC);

  state_t            r_state, w_state_next;
  logic [1:0]        r_idx, w_idx_next;
  logic              r_start_prev, r_armed;
  logic [CNT_W-1:0]  r_wait_cnt, r_byte_cnt;
  logic              r_valid, r_dc, r_busy, r_frame_done;
  logic [DATA_W-1:0] r_data;

  logic [DATA_W-1:0] r_sh_disp_on, r_sh_col, r_sh_row, r_sh_acs, r_sh_mem_wr, r_sh_acs_par;
  logic [DATA_W-1:0] r_sh_col_par [4];
  logic [DATA_W-1:0] r_sh_row_par [4];
  logic [DATA_W-1:0] w_col_par [4];
  logic [DATA_W-1:0] w_row_par [4];

  logic              w_hs, w_start_edge, w_wait_done, w_pix_rdy, w_pix_acc;
  logic              w_frame_end, w_snap, w_upd, w_ld_valid, w_ld_dc;
  logic [DATA_W-1:0] w_ld_data;

  assign w_col_par[0] = cmd_s_col_h_i;
  assign w_col_par[1] = cmd_s_col_l_i;
  assign w_col_par[2] = cmd_e_col_h_i;
  assign w_col_par[3] = cmd_e_col_l_i;
  assign w_row_par[0] = cmd_s_row_h_i;
  assign w_row_par[1] = cmd_s_row_l_i;
  assign w_row_par[2] = cmd_e_row_h_i;
  assign w_row_par[3] = cmd_e_row_l_i;

  // r_armed masks a start level that was already high when reset released
  assign w_start_edge = r_armed & ~r_start_prev & dbi_tx_start_i;
  assign w_hs         = r_valid & dbi_ready_i;
  assign w_wait_done  = ({1'b0, r_wait_cnt} + (CNT_W+1)'(1)) >= LP_WAIT;
  assign w_pix_rdy    = (r_state == S_PIXEL) & (~r_valid | dbi_ready_i) & (r_byte_cnt < LP_FRAME);
  assign w_pix_acc    = w_pix_rdy & pix_valid_i;
  assign w_frame_end  = (r_state == S_PIXEL) & w_hs & (r_byte_cnt == LP_FRAME);
  assign w_snap       = ((r_state == S_IDLE) & w_start_edge) | (w_frame_end & dbi_tx_start_i);
  assign w_upd        = w_hs | w_pix_acc | ((r_state == S_IDLE) & w_start_edge)
                      | ((r_state == S_SRST_WAIT) & w_wait_done);
  assign w_idx_next   = (w_hs & ((r_state == S_COL_PAR) | (r_state == S_ROW_PAR))) ? r_idx + 2'd1 : r_idx;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:      if (w_start_edge) w_state_next = S_SRST_CMD;
      S_SRST_CMD:  if (w_hs) w_state_next = S_SRST_WAIT;
      S_SRST_WAIT: if (w_wait_done) w_state_next = S_DISP_ON;
      S_DISP_ON:   if (w_hs) w_state_next = S_MAD_CMD;
      S_MAD_CMD:   if (w_hs) w_state_next = S_MAD_DAT;
      S_MAD_DAT:   if (w_hs) w_state_next = S_COL_CMD;
      S_COL_CMD:   if (w_hs) w_state_next = S_COL_PAR;
      S_COL_PAR:   if (w_hs && r_idx == 2'd3) w_state_next = S_ROW_CMD;
      S_ROW_CMD:   if (w_hs) w_state_next = S_ROW_PAR;
      S_ROW_PAR:   if (w_hs && r_idx == 2'd3) w_state_next = S_MEMWR_CMD;
      S_MEMWR_CMD: if (w_hs) w_state_next = S_PIXEL;
      S_PIXEL:     if (w_frame_end) w_state_next = dbi_tx_start_i ? S_COL_CMD : S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // The byte of the state being entered is loaded on the same edge as the transition
  always_comb begin
    w_ld_valid = 1'b1;
    w_ld_dc    = 1'b0;
    w_ld_data  = '0;
    case (w_state_next)
      S_SRST_CMD:  w_ld_data = addr_soft_rst_i;
      S_DISP_ON:   w_ld_data = r_sh_disp_on;
      S_MAD_CMD:   w_ld_data = r_sh_acs;
      S_MAD_DAT:   begin w_ld_data = r_sh_acs_par; w_ld_dc = 1'b1; end
      S_COL_CMD:   w_ld_data = w_snap ? addr_col_i : r_sh_col;
      S_COL_PAR:   begin w_ld_data = r_sh_col_par[w_idx_next]; w_ld_dc = 1'b1; end
      S_ROW_CMD:   w_ld_data = r_sh_row;
      S_ROW_PAR:   begin w_ld_data = r_sh_row_par[w_idx_next]; w_ld_dc = 1'b1; end
      S_MEMWR_CMD: w_ld_data = r_sh_mem_wr;
      S_PIXEL: begin
        w_ld_valid = w_pix_acc;
        w_ld_dc    = w_pix_acc;
        w_ld_data  = w_pix_acc ? pix_data_i : '0;
      end
      default:     w_ld_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_start_prev <= 1'b0;
      r_armed      <= 1'b0;
      r_wait_cnt   <= '0;
      r_byte_cnt   <= '0;
      r_valid      <= 1'b0;
      r_dc         <= 1'b0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_idx        <= w_idx_next;
      r_start_prev <= dbi_tx_start_i;
      r_armed      <= 1'b1;
      r_wait_cnt   <= ((r_state == S_SRST_WAIT) && !w_wait_done) ? r_wait_cnt + CNT_W'(1) : '0;
      if (w_frame_end)    r_byte_cnt <= '0;
      else if (w_pix_acc) r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      if (w_upd) begin
        r_valid <= w_ld_valid;
        r_dc    <= w_ld_dc;
        r_data  <= w_ld_data;
      end
      r_busy       <= (w_state_next != S_IDLE);
      r_frame_done <= w_frame_end;
    end
  end

  always_ff @(posedge clk) begin
    if (w_snap) begin
      r_sh_disp_on <= addr_disp_on_i;
      r_sh_col     <= addr_col_i;
      r_sh_row     <= addr_row_i;
      r_sh_acs     <= addr_acs_ctrl_i;
      r_sh_mem_wr  <= addr_mem_wr_i;
      r_sh_acs_par <= cmd_acs_ctrl_i;
      for (int i = 0; i < 4; i++) begin
        r_sh_col_par[i] <= w_col_par[i];
        r_sh_row_par[i] <= w_row_par[i];
      end
    end
  end

  assign pix_ready_o  = w_pix_rdy;
  assign dbi_data_o   = r_data;
  assign dbi_dc_o     = r_dc;
  assign dbi_valid_o  = r_valid;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_dbi_cmd_sequencer.sv
// Directed bench for dbi_cmd_sequencer: a scoreboard queue holds the expected
// {dc,byte} stream and a negedge monitor checks each output handshake.
`define CHK(TAG, OBS, EXP) \
  begin \
    n_checks++; \
    assert ((OBS) === (EXP)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h required %0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_dbi_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       dbi_tx_start_i;
  logic [7:0] addr_soft_rst_i, addr_disp_on_i, addr_col_i, addr_row_i, addr_acs_ctrl_i, addr_mem_wr_i;
  logic [7:0] cmd_s_col_h_i, cmd_s_col_l_i, cmd_e_col_h_i, cmd_e_col_l_i;
  logic [7:0] cmd_s_row_h_i, cmd_s_row_l_i, cmd_e_row_h_i, cmd_e_row_l_i;
  logic [7:0] cmd_acs_ctrl_i, pix_data_i;
  logic       pix_valid_i, pix_ready_o;
  logic [7:0] dbi_data_o;
  logic       dbi_dc_o, dbi_valid_o, dbi_ready_i, busy_o, frame_done_o;

  int n_checks = 0;
  int n_fail = 0;
  int n_fd = 0;
  int n_popped = 0;
  int acc = 0;
  int gap_cnt = 0;
  int last_gap = -1;
  bit gap_on = 0;
  bit pix_phase = 0;
  bit hold_v = 0;
  bit bp_on = 0;
  logic [8:0] held;
  logic [8:0] exp_b;
  logic [8:0] sb [$];

  dbi_cmd_sequencer #(.DATA_W(8), .FRAME_BYTES(4), .RST_WAIT_CYC(4), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .dbi_tx_start_i(dbi_tx_start_i),
    .addr_soft_rst_i(addr_soft_rst_i), .addr_disp_on_i(addr_disp_on_i),
    .addr_col_i(addr_col_i), .addr_row_i(addr_row_i),
    .addr_acs_ctrl_i(addr_acs_ctrl_i), .addr_mem_wr_i(addr_mem_wr_i),
    .cmd_s_col_h_i(cmd_s_col_h_i), .cmd_s_col_l_i(cmd_s_col_l_i),
    .cmd_e_col_h_i(cmd_e_col_h_i), .cmd_e_col_l_i(cmd_e_col_l_i),
    .cmd_s_row_h_i(cmd_s_row_h_i), .cmd_s_row_l_i(cmd_s_row_l_i),
    .cmd_e_row_h_i(cmd_e_row_h_i), .cmd_e_row_l_i(cmd_e_row_l_i),
    .cmd_acs_ctrl_i(cmd_acs_ctrl_i), .pix_data_i(pix_data_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .dbi_data_o(dbi_data_o), .dbi_dc_o(dbi_dc_o), .dbi_valid_o(dbi_valid_o),
    .dbi_ready_i(dbi_ready_i), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output monitor: scoreboard pops, stall stability, pixel-ready legality
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 0; pix_phase = 0; acc = 0; gap_on = 0;
    end else begin
      if (hold_v) begin
        n_checks++;
        if (dbi_valid_o !== 1'b1) begin
          n_fail++;
          $error("FAIL hold_valid: observed %0h required 1", dbi_valid_o);
        end
        n_checks++;
        if ({dbi_dc_o, dbi_data_o} !== held) begin
          n_fail++;
          $error("FAIL hold_byte: observed %0h required %0h", {dbi_dc_o, dbi_data_o}, held);
        end
      end
      if (pix_ready_o) begin
        n_checks++;
        if (pix_phase !== 1'b1) begin
          n_fail++;
          $error("FAIL pix_ready_phase: pix_ready_o high outside PIXEL");
        end
        n_checks++;
        if (acc >= 4) begin
          n_fail++;
          $error("FAIL pix_ready_count: pix_ready_o high after %0d accepted", acc);
        end
      end
      if (pix_valid_i && pix_ready_o) acc++;
      if (gap_on) begin
        if (dbi_valid_o) begin gap_on = 0; last_gap = gap_cnt; end
        else gap_cnt++;
      end
      if (dbi_valid_o && dbi_ready_i) begin
        $display("byte %0d: dc=%0d data=%02h", n_popped, dbi_dc_o, dbi_data_o);
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $error("FAIL sb_nonempty: unexpected byte %02h", dbi_data_o);
        end else begin
          exp_b = sb.pop_front();
          n_checks++;
          if ({dbi_dc_o, dbi_data_o} !== exp_b) begin
            n_fail++;
            $error("FAIL byte: observed %0h required %0h", {dbi_dc_o, dbi_data_o}, exp_b);
          end
        end
        n_popped++;
        if (!dbi_dc_o && dbi_data_o == 8'h01) begin gap_on = 1; gap_cnt = 0; end
        if (!dbi_dc_o && dbi_data_o == 8'h2C) pix_phase = 1;
      end
      if (frame_done_o) begin n_fd++; pix_phase = 0; acc = 0; end
      hold_v = dbi_valid_o && !dbi_ready_i;
      held = {dbi_dc_o, dbi_data_o};
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic dc, input logic [7:0] b);
    sb.push_back({dc, b});
  endtask

  task automatic push_init();
    push(0, 8'h01); push(0, 8'h29); push(0, 8'h36); push(1, 8'h48);
  endtask

  task automatic push_win(input logic [7:0] ecl);
    push(0, 8'h2A); push(1, 8'h00); push(1, 8'h00); push(1, 8'h00); push(1, ecl);
    push(0, 8'h2B); push(1, 8'h00); push(1, 8'h00); push(1, 8'h01); push(1, 8'h3F);
    push(0, 8'h2C);
  endtask

  task automatic push_pix(input logic [7:0] base);
    for (int i = 0; i < 4; i++) push(1, base + 8'(i));
  endtask

  task automatic pulse_start();
    dbi_tx_start_i = 1;
    tick();
    dbi_tx_start_i = 0;
    @(negedge clk);
    `CHK("busy_after_start", busy_o, 1'b1);
    tick();
  endtask

  task automatic wait_fd(input int target);
    for (int i = 0; i < 3000 && n_fd < target; i++) @(negedge clk);
    `CHK("frame_done_wait", (n_fd >= target), 1'b1);
  endtask

  task automatic wait_pop(input int target);
    for (int i = 0; i < 3000 && n_popped < target; i++) @(negedge clk);
    `CHK("byte_wait", (n_popped >= target), 1'b1);
  endtask

  task automatic send_pixels(input logic [7:0] base, input bit gaps);
    bit ok;
    for (int i = 0; i < 4; i++) begin
      pix_data_i = base + 8'(i);
      pix_valid_i = 1;
      ok = 0;
      for (int t = 0; t < 3000 && !ok; t++) begin
        @(negedge clk);
        ok = pix_ready_o;
        tick();
      end
      pix_valid_i = 0;
      `CHK("pix_accept", ok, 1'b1);
      if (gaps) begin tick(); tick(); end
    end
  endtask

  task automatic toggle_ready();
    while (bp_on) begin
      tick();
      dbi_ready_i = ~dbi_ready_i;
    end
  endtask

  initial begin
    int f0, p0;
    rst = 1; dbi_tx_start_i = 1; dbi_ready_i = 1; pix_valid_i = 0; pix_data_i = 0;
    addr_soft_rst_i = 8'h01; addr_disp_on_i = 8'h29; addr_col_i = 8'h2A;
    addr_row_i = 8'h2B; addr_acs_ctrl_i = 8'h36; addr_mem_wr_i = 8'h2C;
    cmd_s_col_h_i = 8'h00; cmd_s_col_l_i = 8'h00; cmd_e_col_h_i = 8'h00; cmd_e_col_l_i = 8'hEF;
    cmd_s_row_h_i = 8'h00; cmd_s_row_l_i = 8'h00; cmd_e_row_h_i = 8'h01; cmd_e_row_l_i = 8'h3F;
    cmd_acs_ctrl_i = 8'h48;
    repeat (3) tick();
    @(negedge clk);
    `CHK("rst_valid", dbi_valid_o, 1'b0);
    `CHK("rst_data", dbi_data_o, 8'h00);
    `CHK("rst_dc", dbi_dc_o, 1'b0);
    `CHK("rst_busy", busy_o, 1'b0);
    `CHK("rst_frame_done", frame_done_o, 1'b0);
    `CHK("rst_pix_ready", pix_ready_o, 1'b0);
    tick();
    rst = 0;
    repeat (6) tick();
    @(negedge clk);
    `CHK("held_start_no_busy", busy_o, 1'b0);
    `CHK("held_start_no_valid", dbi_valid_o, 1'b0);
    tick();
    dbi_tx_start_i = 0;
    repeat (2) tick();

    // Basic sequence, ready always high
    f0 = n_fd;
    push_init(); push_win(8'hEF); push_pix(8'hA1);
    pulse_start();
    fork
      send_pixels(8'hA1, 0);
      wait_fd(f0 + 1);
    join
    repeat (2) tick();
    `CHK("s1_srst_gap", last_gap, 4);
    `CHK("s1_busy_low", busy_o, 1'b0);
    `CHK("s1_fd_count", n_fd, f0 + 1);
    `CHK("s1_sb_empty", sb.size(), 0);

    // Backpressure: ready toggles each cycle
    f0 = n_fd; last_gap = -1;
    push_init(); push_win(8'hEF); push_pix(8'hA1);
    bp_on = 1;
    fork
      toggle_ready();
      begin
        pulse_start();
        fork
          send_pixels(8'hA1, 0);
          wait_fd(f0 + 1);
        join
        bp_on = 0;
      end
    join
    dbi_ready_i = 1;
    repeat (2) tick();
    `CHK("s2_srst_gap", last_gap, 4);
    `CHK("s2_busy_low", busy_o, 1'b0);
    `CHK("s2_fd_count", n_fd, f0 + 1);
    `CHK("s2_sb_empty", sb.size(), 0);

    // Start held across three frames, window end column changed mid COL_PAR
    f0 = n_fd; p0 = n_popped;
    push_init(); push_win(8'hEF); push_pix(8'hB1);
    push_win(8'h7F); push_pix(8'hC1);
    push_win(8'h7F); push_pix(8'hD1);
    dbi_tx_start_i = 1;
    tick();
    fork
      begin send_pixels(8'hB1, 0); send_pixels(8'hC1, 0); send_pixels(8'hD1, 0); end
      begin
        wait_pop(p0 + 6);
        cmd_e_col_l_i = 8'h7F;
        wait_fd(f0 + 1);
        `CHK("s3_loop_busy", busy_o, 1'b1);
        wait_fd(f0 + 2);
        tick();
        dbi_tx_start_i = 0;
        wait_fd(f0 + 3);
      end
    join
    cmd_e_col_l_i = 8'hEF;
    repeat (2) tick();
    `CHK("s3_busy_low", busy_o, 1'b0);
    `CHK("s3_fd_count", n_fd, f0 + 3);
    `CHK("s3_sb_empty", sb.size(), 0);

    // Pixel gaps plus an ignored start pulse while busy
    f0 = n_fd;
    push_init(); push_win(8'hEF); push_pix(8'hF1);
    pulse_start();
    fork
      send_pixels(8'hF1, 1);
      begin repeat (3) tick(); pulse_start(); end
      wait_fd(f0 + 1);
    join
    repeat (3) tick();
    `CHK("s5_busy_low", busy_o, 1'b0);
    `CHK("s5_fd_count", n_fd, f0 + 1);
    `CHK("s5_sb_empty", sb.size(), 0);

    // Reset while a ROW_PAR byte is stalled, then full replay
    p0 = n_popped;
    push_init(); push_win(8'hEF);
    pulse_start();
    wait_pop(p0 + 11);
    tick();
    dbi_ready_i = 0;
    repeat (2) tick();
    @(negedge clk);
    `CHK("s6_stalled_valid", dbi_valid_o, 1'b1);
    tick();
    rst = 1;
    tick();
    @(negedge clk);
    `CHK("s6_rst_valid", dbi_valid_o, 1'b0);
    `CHK("s6_rst_busy", busy_o, 1'b0);
    sb.delete();
    tick();
    rst = 0; dbi_ready_i = 1;
    repeat (3) tick();
    f0 = n_fd; last_gap = -1;
    push_init(); push_win(8'hEF); push_pix(8'hE1);
    pulse_start();
    fork
      send_pixels(8'hE1, 0);
      wait_fd(f0 + 1);
    join
    repeat (2) tick();
    `CHK("s6_srst_gap", last_gap, 4);
    `CHK("s6_busy_low", busy_o, 1'b0);
    `CHK("s6_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
